// File: rtl/axi2s_pkg.sv
// Shared AXI3 write-port constants and the burst arbiter's state encoding.
package axi2s_pkg;
  localparam logic [5:0] AXI_ID     = 6'h3F;
  localparam logic [3:0] AXI_LEN16  = 4'hF;
  localparam logic [2:0] AXI_SIZE4B = 3'b010;
  localparam logic [1:0] AXI_INCR   = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
endpackage

// File: rtl/axi_wr_order_fifo.sv
// Small synchronous FIFO; used both for B-response ordering and as the W skid buffer.
module axi_wr_order_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         gclk,
  input  logic         grst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic [AW:0]  count
);
  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wptr, rptr;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge gclk) begin
    if (push) mem[wptr] <= din;
  end

  assign dout  = mem[rptr];
  assign empty = (count == '0);
endmodule

// File: rtl/axi_wr_burst_arb.sv
// Round-robin arbiter sharing one AXI3 write port between NREQ burst requesters,
// prefetching each burst from the winner's buffer and routing B status back in order.
module axi_wr_burst_arb
  import axi2s_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int BEATS     = 16,
  parameter int MAX_OUTST = 4
) (
  input  logic                  AXI_clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0][31:0] req_addr,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       buf_en,
  output logic [3:0]            buf_addr,
  input  logic [NREQ-1:0][31:0] buf_data,
  output logic [NREQ-1:0]       done,
  output logic [NREQ-1:0]       err,
  input  logic                  err_clr,
  output logic [5:0]            AXI_awid,
  output logic [31:0]           AXI_awaddr,
  output logic [3:0]            AXI_awlen,
  output logic [2:0]            AXI_awsize,
  output logic [1:0]            AXI_awburst,
  output logic                  AXI_awvalid,
  input  logic                  AXI_awready,
  output logic [5:0]            AXI_wid,
  output logic [31:0]           AXI_wdata,
  output logic [3:0]            AXI_wstrb,
  output logic                  AXI_wlast,
  output logic                  AXI_wvalid,
  input  logic                  AXI_wready,
  input  logic [1:0]            AXI_bresp,
  input  logic                  AXI_bvalid,
  output logic                  AXI_bready
);
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int OAW = $clog2(MAX_OUTST);
  localparam logic [OAW:0] MAXC   = (OAW+1)'(MAX_OUTST);
  localparam logic [4:0]   BEATSC = 5'(BEATS);
  localparam logic [3:0]   LASTB  = 4'(BEATS - 1);

  state_t        state, state_nx;
  logic [IW-1:0] idx, rr, rr_nx, pick;
  logic [IW:0]   cand;
  logic          found, start;
  logic [31:0]   addr_q;
  logic [4:0]    rd_cnt;
  logic [3:0]    wbeat;
  logic          inflight, rd_issue;
  logic          aw_hs, w_hs, last_hs, b_hs;

  logic          sk_empty;
  logic [1:0]    sk_count;
  logic [31:0]   sk_dout;
  logic          ord_empty;
  logic [OAW:0]  ord_count;
  logic [IW-1:0] ord_dout;

  // First requester at or after rr, cyclically.
  always_comb begin
    found = 1'b0;
    pick  = rr;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IW-1:0];
      end
    end
  end

  assign start = found && (ord_count < MAXC);
  assign rr_nx = (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;

  always_ff @(posedge AXI_clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      idx      <= '0;
      rr       <= '0;
      addr_q   <= '0;
      rd_cnt   <= '0;
      wbeat    <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_nx;
      inflight <= rd_issue;
      if (state == IDLE && start) begin
        idx    <= pick;
        addr_q <= req_addr[pick];
      end
      if (aw_hs)    rr     <= rr_nx;
      if (rd_issue) rd_cnt <= rd_cnt + 1'b1;
      if (w_hs)     wbeat  <= wbeat + 1'b1;
      if (last_hs) begin
        rd_cnt <= '0;
        wbeat  <= '0;
      end
    end
  end

  always_comb begin
    state_nx    = state;
    grant       = '0;
    buf_en      = '0;
    AXI_awvalid = 1'b0;
    rd_issue    = 1'b0;
    case (state)
      IDLE: if (start) state_nx = ADDR;
      ADDR: begin
        AXI_awvalid = 1'b1;
        if (AXI_awready) begin
          grant[idx] = 1'b1;
          state_nx   = DATA;
        end
      end
      DATA: begin
        // Skid occupancy after this cycle's pop, plus the read already in flight.
        rd_issue = (rd_cnt < BEATSC) &&
                   ((sk_count - {1'b0, w_hs} + {1'b0, inflight}) < 2'd2);
        buf_en[idx] = rd_issue;
        if (last_hs) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign aw_hs      = AXI_awvalid && AXI_awready;
  assign AXI_wvalid = (state == DATA) && !sk_empty;
  assign w_hs       = AXI_wvalid && AXI_wready;
  assign AXI_wlast  = AXI_wvalid && (wbeat == LASTB);
  assign last_hs    = w_hs && AXI_wlast;
  assign AXI_wdata  = AXI_wvalid ? sk_dout : '0;
  assign AXI_awaddr = addr_q & ~32'h3F;
  assign buf_addr   = rd_cnt[3:0];

  assign AXI_awid    = AXI_ID;
  assign AXI_wid     = AXI_ID;
  assign AXI_awlen   = AXI_LEN16;
  assign AXI_awsize  = AXI_SIZE4B;
  assign AXI_awburst = AXI_INCR;
  assign AXI_wstrb   = 4'hF;

  axi_wr_order_fifo #(.W(32), .DEPTH(2)) u_skid (
    .gclk   (AXI_clk),
    .grst_n (rst),
    .push   (inflight),
    .din    (buf_data[idx]),
    .pop    (w_hs),
    .dout   (sk_dout),
    .empty  (sk_empty),
    .count  (sk_count)
  );

  axi_wr_order_fifo #(.W(IW), .DEPTH(MAX_OUTST)) u_order (
    .gclk   (AXI_clk),
    .grst_n (rst),
    .push   (aw_hs),
    .din    (idx),
    .pop    (b_hs),
    .dout   (ord_dout),
    .empty  (ord_empty),
    .count  (ord_count)
  );

  assign AXI_bready = !ord_empty;
  assign b_hs       = AXI_bvalid && AXI_bready;

  always_comb begin
    done = '0;
    if (b_hs) done[ord_dout] = 1'b1;
  end

  // A new error outranks a simultaneous clear.
  always_ff @(posedge AXI_clk or negedge rst) begin
    if (!rst) err <= '0;
    else      err <= (err & ~{NREQ{err_clr}}) | (done & {NREQ{AXI_bresp != RESP_OKAY}});
  end
endmodule

// File: tb/tb_axi_wr_burst_arb.sv
// Scoreboard bench: tests queue expected AW/W/B traffic, a negedge monitor checks it.
module tb_axi_wr_burst_arb;
  localparam int NREQ = 2;

  logic                  AXI_clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ-1:0][31:0] req_addr;
  logic [NREQ-1:0]       grant, buf_en, done, err;
  logic [3:0]            buf_addr;
  logic [NREQ-1:0][31:0] buf_data = '0;
  logic                  err_clr = 1'b0;
  logic [5:0]            AXI_awid, AXI_wid;
  logic [31:0]           AXI_awaddr, AXI_wdata;
  logic [3:0]            AXI_awlen, AXI_wstrb;
  logic [2:0]            AXI_awsize;
  logic [1:0]            AXI_awburst;
  logic                  AXI_awvalid, AXI_awready = 1'b1;
  logic                  AXI_wlast, AXI_wvalid, AXI_wready = 1'b1;
  logic [1:0]            AXI_bresp = 2'b00;
  logic                  AXI_bvalid = 1'b0, AXI_bready;

  axi_wr_burst_arb #(.NREQ(NREQ), .BEATS(16), .MAX_OUTST(4)) dut (
    .AXI_clk(AXI_clk), .rst(rst), .req(req), .req_addr(req_addr), .grant(grant),
    .buf_en(buf_en), .buf_addr(buf_addr), .buf_data(buf_data), .done(done), .err(err),
    .err_clr(err_clr), .AXI_awid(AXI_awid), .AXI_awaddr(AXI_awaddr), .AXI_awlen(AXI_awlen),
    .AXI_awsize(AXI_awsize), .AXI_awburst(AXI_awburst), .AXI_awvalid(AXI_awvalid),
    .AXI_awready(AXI_awready), .AXI_wid(AXI_wid), .AXI_wdata(AXI_wdata), .AXI_wstrb(AXI_wstrb),
    .AXI_wlast(AXI_wlast), .AXI_wvalid(AXI_wvalid), .AXI_wready(AXI_wready),
    .AXI_bresp(AXI_bresp), .AXI_bvalid(AXI_bvalid), .AXI_bready(AXI_bready)
  );

  initial forever #5 AXI_clk = ~AXI_clk;

  typedef struct { logic [31:0] addr; int idx; } aw_t;
  aw_t         exp_aw[$];
  logic [32:0] exp_w[$];
  int          exp_b[$];

  int          n_chk = 0, n_pass = 0;
  logic [31:0] base[NREQ];
  logic [1:0]  resp_cfg[NREQ];
  int          remaining[NREQ];
  int          aw_delay = 0, aw_wait = 0;
  bit          w_rand = 0, b_en = 1, clr_pend = 0, clr_active = 0;
  int          aw_idx_q[$];
  logic [1:0]  b_rdy_q[$];

  bit          hs_aw, hs_w, hs_b, hs_wlast;
  int          hs_aw_idx;
  int          aw_cnt = 0, wlast_cnt = 0, w_in_burst = 0, awvalid_hi = 0;
  bit          p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_wlast = 0;
  logic [31:0] p_awaddr, p_wdata;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  function automatic void flag(string nm, string why);
    n_chk++;
    $display("FAIL %s: %s", nm, why);
  endfunction

  // Requester buffers: 1-cycle read latency, data = base + beat index.
  always @(posedge AXI_clk)
    for (int i = 0; i < NREQ; i++)
      if (buf_en[i]) buf_data[i] <= base[i] + {28'b0, buf_addr};

  // Monitor / scoreboard: whatever is seen here handshakes at the next posedge.
  initial begin
    aw_t         e;
    logic [32:0] ew;
    int          eb;
    forever begin
      @(negedge AXI_clk);
      hs_aw = 0; hs_w = 0; hs_b = 0; hs_wlast = 0; hs_aw_idx = -1;
      if (!rst) begin
        p_awv = 0; p_wv = 0; w_in_burst = 0;
      end else begin
        if (p_awv && !p_awr) check("aw_hold", {AXI_awvalid, AXI_awaddr}, {1'b1, p_awaddr});
        if (p_wv && !p_wr) check("w_hold", {AXI_wvalid, AXI_wlast, AXI_wdata}, {1'b1, p_wlast, p_wdata});
        if (AXI_wvalid) check("w_after_aw", 64'(aw_cnt > wlast_cnt), 64'd1);
        if (AXI_awvalid) awvalid_hi++;
        if (AXI_awvalid && AXI_awready) begin
          hs_aw = 1; aw_cnt++;
          for (int i = 0; i < NREQ; i++) if (grant[i]) hs_aw_idx = i;
          if (exp_aw.size() == 0) flag("aw_unexpected", $sformatf("addr %0h", AXI_awaddr));
          else begin
            e = exp_aw.pop_front();
            check("awaddr", AXI_awaddr, e.addr);
            check("grant", grant, 64'd1 << e.idx);
          end
        end
        if (AXI_wvalid && AXI_wready) begin
          hs_w = 1; w_in_burst++;
          if (exp_w.size() == 0) flag("w_unexpected", $sformatf("data %0h", AXI_wdata));
          else begin
            ew = exp_w.pop_front();
            check("wbeat", {AXI_wlast, AXI_wdata}, ew);
          end
          if (AXI_wlast) begin hs_wlast = 1; wlast_cnt++; w_in_burst = 0; end
        end
        if (AXI_bvalid && AXI_bready) begin
          hs_b = 1;
          if (exp_b.size() == 0) flag("b_unexpected", $sformatf("done %0b", done));
          else begin
            eb = exp_b.pop_front();
            check("done", done, 64'd1 << eb);
          end
        end
        p_awv = AXI_awvalid; p_awr = AXI_awready; p_awaddr = AXI_awaddr;
        p_wv = AXI_wvalid; p_wr = AXI_wready; p_wdata = AXI_wdata; p_wlast = AXI_wlast;
      end
    end
  end

  // AXI slave + requester models, acting on handshakes seen by the monitor.
  initial begin
    int k;
    forever begin
      @(posedge AXI_clk); #1;
      if (rst) begin
        if (hs_aw && hs_aw_idx >= 0) begin
          remaining[hs_aw_idx]--;
          aw_idx_q.push_back(hs_aw_idx);
        end
        if (hs_wlast && aw_idx_q.size() > 0) begin
          k = aw_idx_q.pop_front();
          b_rdy_q.push_back(resp_cfg[k]);
        end
        if (clr_active) begin err_clr = 0; clr_active = 0; end
        if (hs_b) begin
          AXI_bvalid = 0;
          if (b_rdy_q.size() > 0) void'(b_rdy_q.pop_front());
        end else if (!AXI_bvalid && b_en && b_rdy_q.size() > 0) begin
          AXI_bvalid = 1; AXI_bresp = b_rdy_q[0];
          if (clr_pend) begin err_clr = 1; clr_active = 1; clr_pend = 0; end
        end
        AXI_wready = w_rand ? ($urandom_range(0, 99) < 30) : 1'b1;
        if (hs_aw) aw_wait = 0;
        else if (AXI_awvalid) aw_wait++;
        AXI_awready = (aw_delay == 0) || (AXI_awvalid && !hs_aw && aw_wait >= aw_delay);
        for (int i = 0; i < NREQ; i++) req[i] = (remaining[i] > 0);
      end
    end
  end

  task automatic push_burst(input int i);
    exp_aw.push_back('{addr: req_addr[i] & ~32'h3F, idx: i});
    for (int b = 0; b < 16; b++) exp_w.push_back({b == 15, base[i] + 32'(b)});
    exp_b.push_back(i);
    remaining[i]++;
    req[i] = 1'b1;
  endtask

  task automatic wait_drain(input string nm, input int maxc);
    int c = 0;
    while ((exp_aw.size() + exp_w.size() + exp_b.size()) != 0 && c < maxc) begin
      @(posedge AXI_clk); c++;
    end
    if (c >= maxc) flag(nm, "timed out waiting for expected traffic");
    repeat (30) @(posedge AXI_clk);
  endtask

  initial begin
    int c, a0, h0;
    base[0] = 32'h0;          base[1] = 32'h100;
    req_addr[0] = 32'h1000_0040; req_addr[1] = 32'h2000_00A5;
    resp_cfg[0] = 2'b00;      resp_cfg[1] = 2'b00;
    remaining[0] = 0;         remaining[1] = 0;

    #23;
    check("rst_awvalid", AXI_awvalid, 0);
    check("rst_wvalid", AXI_wvalid, 0);
    check("rst_bready", AXI_bready, 0);
    check("rst_grant_done", {grant, done}, 0);
    check("rst_err_bufen", {err, buf_en}, 0);
    @(negedge AXI_clk); #2 rst = 1'b1;

    // Contention from reset: rr starts at 0.
    push_burst(0); push_burst(1); push_burst(0); push_burst(1);
    wait_drain("contention", 400);

    // Single requester, data 0..15.
    push_burst(0);
    wait_drain("single", 200);

    // Backpressure; rr now points at requester 1.
    aw_delay = 5; w_rand = 1;
    push_burst(1); push_burst(0);
    wait_drain("backpressure", 2000);
    aw_delay = 0; w_rand = 0;

    // Error path.
    resp_cfg[1] = 2'b10;
    push_burst(1);
    wait_drain("err_first", 200);
    check("err_set", err, 2'b10);
    b_en = 0;
    push_burst(1);
    c = 0;
    while (b_rdy_q.size() == 0 && c < 300) begin @(posedge AXI_clk); c++; end
    if (c >= 300) flag("err_second", "burst never completed");
    clr_pend = 1; b_en = 1;
    wait_drain("err_second_b", 100);
    check("err_clr_vs_new", err, 2'b10);
    @(posedge AXI_clk); #1 err_clr = 1'b1;
    @(posedge AXI_clk); #1 err_clr = 1'b0;
    #1 check("err_clr", err, 2'b00);
    resp_cfg[1] = 2'b00;

    // Outstanding limit.
    b_en = 0; a0 = aw_cnt;
    for (int n = 0; n < 5; n++) push_burst(0);
    c = 0;
    while (exp_w.size() > 16 && c < 400) begin @(posedge AXI_clk); c++; end
    if (c >= 400) flag("outst_fill", "four bursts did not complete");
    h0 = awvalid_hi;
    repeat (40) @(posedge AXI_clk);
    check("outst_aw_count", aw_cnt - a0, 4);
    check("outst_awvalid_low", awvalid_hi - h0, 0);
    check("outst_bready", AXI_bready, 1);
    b_en = 1;
    c = 0;
    while (aw_cnt - a0 < 5 && c < 100) begin @(posedge AXI_clk); c++; end
    if (c >= 100) flag("outst_fifth", "no AW after B release");
    wait_drain("outst_drain", 400);

    // Reset mid-DATA at beat 7.
    push_burst(0);
    c = 0;
    while (w_in_burst != 7 && c < 200) begin @(posedge AXI_clk); c++; end
    if (c >= 200) flag("rst_mid_wait", "beat 7 never reached");
    #3 rst = 1'b0;
    #1;
    check("mid_awvalid_wvalid", {AXI_awvalid, AXI_wvalid, AXI_wlast}, 0);
    check("mid_wdata", AXI_wdata, 0);
    check("mid_bready", AXI_bready, 0);
    check("mid_bufen_addr", {buf_en, buf_addr}, 0);
    check("mid_grant_done_err", {grant, done, err}, 0);
    exp_aw.delete(); exp_w.delete(); exp_b.delete();
    aw_idx_q.delete(); b_rdy_q.delete();
    remaining[0] = 0; remaining[1] = 0; req = '0; AXI_bvalid = 1'b0;
    repeat (3) @(posedge AXI_clk);
    @(negedge AXI_clk); #2 rst = 1'b1;
    push_burst(0);
    wait_drain("after_reset", 200);

    check("final_queues", exp_aw.size() + exp_w.size() + exp_b.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
